// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU:
// data width, control encodings and FSM states.
package alu_serial_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_NOR = 4'b1100,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_valid_ctrl(input logic [3:0] c);
        case (c)
            ALU_AND, ALU_OR, ALU_ADD,
            ALU_SUB, ALU_NOR, ALU_SLT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_addsub(input logic [3:0] c);
        return (c == ALU_ADD) || (c == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// One-bit ALU slice: optional operand inversion,
// AND / OR / full-add selected by operation.
module alu_slice_1b (
    input  logic       a,
    input  logic       b,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout,
    output logic       sum
);

    logic a_x;
    logic b_x;

    always_comb begin
        a_x  = a ^ A_invert;
        b_x  = b ^ B_invert;
        sum  = a_x ^ b_x ^ cin;
        cout = (a_x & b_x) | (cin & (a_x ^ b_x));
        unique case (operation)
            2'b00:   result = a_x & b_x;
            2'b01:   result = a_x | b_x;
            2'b10:   result = sum;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial 32-bit ALU: one bit per clock, LSB first,
// through a single alu_slice_1b.
module alu_serial
    import alu_serial_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [3:0]        ALU_control_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              cout_o,
    output logic              overflow_o
);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        ctrl_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;
    logic              res_vld_q;

    logic              accept;
    logic              last_bit;
    logic              s_res;
    logic              s_cout;
    logic              s_sum;
    logic              bit_val;
    logic              less;

    assign accept   = start_i && (state_q != ST_RUN);
    assign last_bit = &cnt_q;

    alu_slice_1b u_slice (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .A_invert  (ctrl_q[3]),
        .B_invert  (ctrl_q[2]),
        .cin       (carry_q),
        .operation (ctrl_q[1:0]),
        .result    (s_res),
        .cout      (s_cout),
        .sum       (s_sum)
    );

    // SLT writes zeros bit by bit; its verdict lands in bit 0 at the end
    always_comb begin
        bit_val = 1'b0;
        if (is_valid_ctrl(ctrl_q) && (ctrl_q != ALU_SLT)) begin
            bit_val = s_res;
        end
        less = s_sum ^ (carry_q ^ s_cout);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            ctrl_q    <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            res_vld_q <= 1'b0;
        end else if (accept) begin
            a_q     <= src1_i;
            b_q     <= src2_i;
            ctrl_q  <= ALU_control_i;
            carry_q <= ALU_control_i[2];
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == ST_RUN) begin
            a_q          <= a_q >> 1;
            b_q          <= b_q >> 1;
            carry_q      <= s_cout;
            cnt_q        <= cnt_q + CNT_W'(1);
            res_q[cnt_q] <= bit_val;
            if (last_bit) begin
                res_vld_q <= 1'b1;
                if (ctrl_q == ALU_SLT) begin
                    res_q[0] <= less;
                end
                if (is_addsub(ctrl_q)) begin
                    cout_q <= s_cout;
                    ovf_q  <= carry_q ^ s_cout;
                end
            end
        end
    end

    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign result_o   = res_q;
    assign zero_o     = res_vld_q && (res_q == '0);
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial with an
// expected-result scoreboard.
module tb_alu_serial;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  ctrl = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        cout_o;
    logic        overflow_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_serial dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .src1_i        (a),
        .src2_i        (b),
        .ALU_control_i (ctrl),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o),
        .zero_o        (zero_o),
        .cout_o        (cout_o),
        .overflow_o    (overflow_o)
    );

    function automatic exp_t model(input logic [3:0] c,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t        e;
        logic [32:0] w;
        e = '0;
        case (c)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: begin
                w      = {1'b0, x} + {1'b0, y};
                e.res  = w[31:0];
                e.cout = w[32];
                e.ovf  = (x[31] == y[31]) && (e.res[31] != x[31]);
            end
            4'b0110: begin
                e.res  = x - y;
                e.cout = (x >= y);
                e.ovf  = (x[31] != y[31]) && (e.res[31] != x[31]);
            end
            4'b1100: e.res = ~(x | y);
            4'b0111: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drives one accepted start; returns #1 after the start edge.
    task automatic start_op(input logic [3:0] c,
                            input logic [31:0] x,
                            input logic [31:0] y);
        ctrl  = c;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(c, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ctrl  = 4'($urandom);
    endtask

    // cyc = index of cycle after the start edge in which done_o is seen
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = -1;
        busy_n = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) begin
                cyc = n;
                return;
            end
            if (busy_o) busy_n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctl: busy/done=%b want 00", {busy_o, done_o});
        end
        checks++;
        if ({result_o, zero_o, cout_o, overflow_o} !== 35'd0) begin
            errors++;
            $display("FAIL reset_out: res=%h z=%b c=%b v=%b want all 0",
                     result_o, zero_o, cout_o, overflow_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_ovf;
        int   cyc;
        int   bn;
        exp_t e;
        @(negedge clk);
        start_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_done(cyc, bn);
        e = sb.pop_front();
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL add_latency: done in cycle %0d after start edge, want 32", cyc);
        end
        checks++;
        if (bn !== 32) begin
            errors++;
            $display("FAIL add_busy: busy cycles %0d want 32", bn);
        end
        checks++;
        if ({result_o, zero_o, cout_o, overflow_o} !== e
            || e.res !== 32'h8000_0000 || e.ovf !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf: res=%h z=%b c=%b v=%b want res=80000000 z=0 c=0 v=1",
                     result_o, zero_o, cout_o, overflow_o);
        end
        @(negedge clk);
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: busy/done=%b want 00", {busy_o, done_o});
        end
    endtask

    task automatic test_sub_zero;
        int   cyc;
        int   bn;
        exp_t e;
        @(negedge clk);
        start_op(4'b0110, 32'd5, 32'd5);
        wait_done(cyc, bn);
        e = sb.pop_front();
        checks++;
        if ({result_o, zero_o, cout_o, overflow_o} !== e
            || e.zero !== 1'b1 || e.cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: res=%h z=%b c=%b v=%b want res=0 z=1 c=1 v=0",
                     result_o, zero_o, cout_o, overflow_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({result_o, zero_o, cout_o, overflow_o} !== e) begin
            errors++;
            $display("FAIL sub_hold: res=%h z=%b c=%b v=%b want %h %b %b %b",
                     result_o, zero_o, cout_o, overflow_o,
                     e.res, e.zero, e.cout, e.ovf);
        end
    endtask

    task automatic test_slt;
        logic [31:0] xs [2];
        logic [31:0] ys [2];
        logic [31:0] want [2];
        int          cyc;
        int          bn;
        exp_t        e;
        xs   = '{32'h8000_0000, 32'h7FFF_FFFF};
        ys   = '{32'h0000_0001, 32'hFFFF_FFFF};
        want = '{32'd1, 32'd0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start_op(4'b0111, xs[i], ys[i]);
            wait_done(cyc, bn);
            e = sb.pop_front();
            checks++;
            if ({result_o, zero_o, cout_o, overflow_o} !== e
                || e.res !== want[i]) begin
                errors++;
                $display("FAIL slt_%0d: res=%h z=%b c=%b v=%b want res=%h c=0 v=0",
                         i, result_o, zero_o, cout_o, overflow_o, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        int   bn;
        exp_t e;
        @(negedge clk);
        start_op(4'b1100, 32'h0, 32'h0);
        wait_done(cyc, bn);
        e = sb.pop_front();
        checks++;
        if ({result_o, zero_o, cout_o, overflow_o} !== e
            || e.res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL nor: res=%h want ffffffff", result_o);
        end
        start_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b want 1", busy_o);
        end
        wait_done(cyc, bn);
        e = sb.pop_front();
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL b2b_latency: cycle %0d want 32", cyc);
        end
        checks++;
        if ({result_o, zero_o, cout_o, overflow_o} !== e
            || e.res !== 32'hF000_F000) begin
            errors++;
            $display("FAIL b2b_and: res=%h want f000f000", result_o);
        end
    endtask

    task automatic test_invalid;
        logic [3:0] codes [3];
        int         cyc;
        int         bn;
        exp_t       e;
        codes = '{4'b0011, 4'b1111, 4'b1010};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_op(codes[i], $urandom | 32'h1, 32'hFFFF_FFFF);
            wait_done(cyc, bn);
            e = sb.pop_front();
            checks++;
            if ({result_o, zero_o, cout_o, overflow_o} !== e) begin
                errors++;
                $display("FAIL invalid_%b: res=%h z=%b c=%b v=%b want 0 1 0 0",
                         codes[i], result_o, zero_o, cout_o, overflow_o);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  codes [6];
        logic [3:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        int          cyc;
        int          bn;
        exp_t        e;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
        for (int i = 0; i < 12; i++) begin
            c = codes[i % 6];
            x = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            @(negedge clk);
            start_op(c, x, y);
            wait_done(cyc, bn);
            e = sb.pop_front();
            checks++;
            if ({result_o, zero_o, cout_o, overflow_o} !== e) begin
                errors++;
                $display("FAIL rand_%0d op=%b a=%h b=%h: res=%h z=%b c=%b v=%b want %h %b %b %b",
                         i, c, x, y, result_o, zero_o, cout_o, overflow_o,
                         e.res, e.zero, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_abort;
        int   cyc;
        int   bn;
        bit   seen;
        exp_t e;
        @(negedge clk);
        ctrl  = 4'b0010;
        a     = 32'h1234_5678;
        b     = 32'h0F0F_0F0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
            if (k == 5) begin
                a = ~a;
                b = ~b;
            end
            if (k == 8) start = 1'b1;
            if (k == 9) start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, result_o, zero_o, cout_o, overflow_o} !== 37'd0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                     busy_o, done_o, result_o, zero_o, cout_o, overflow_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: activity=%b want 0", seen);
        end
        start_op(4'b0001, 32'h1, 32'h2);
        wait_done(cyc, bn);
        e = sb.pop_front();
        checks++;
        if (cyc !== 32 || {result_o, zero_o, cout_o, overflow_o} !== e
            || e.res !== 32'h3) begin
            errors++;
            $display("FAIL after_reset_or: cyc=%0d res=%h want cyc=32 res=3",
                     cyc, result_o);
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_zero();
        test_slt();
        test_back_to_back();
        test_invalid();
        test_random();
        test_abort();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
